// File: rtl/jack_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jack_move_ctrl
// Description : Sprite motion controller for "Jack". On every qualifying tick
//               (tick=1, game=01) it advances a GROUND/RISE/FALL vertical
//               state machine with gravity and a fall-speed cap. It also steps
//               the sprite horizontally from the A/D keys, honouring walls and
//               screen limits. game=00 on a tick re-spawns the sprite.
//               Optional feature macro: JACK_DOUBLE_JUMP_EN (one air jump,
//               restored on landing).
// Revision    : 1.0 - initial release
// ============================================================================
module jack_move_ctrl #(
    parameter int unsigned X_INIT = 0,
    parameter int unsigned Y_INIT = 0,
    parameter int unsigned STEP_X = 2,
    parameter int unsigned JUMP_V = 12,
    parameter int unsigned GRAV   = 1,
    parameter int unsigned VMAX   = 8,
    parameter int unsigned X_MAX  = 504,
    parameter int unsigned Y_MAX  = 360
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic [3:0] wsad_down,
    input  logic [1:0] game,
    input  logic       on_ground,
    input  logic       wall_l,
    input  logic       wall_r,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [2:0] blue_state,
    output logic [4:0] vy
);

    localparam logic [9:0] c_X_INIT = 10'(X_INIT);
    localparam logic [8:0] c_Y_INIT = 9'(Y_INIT);
    localparam logic [9:0] c_STEP_X = 10'(STEP_X);
    localparam logic [4:0] c_JUMP_V = 5'(JUMP_V);
    localparam logic [4:0] c_GRAV   = 5'(GRAV);
    localparam logic [5:0] c_VMAX6  = 6'(VMAX);
    localparam logic [4:0] c_VMAX   = 5'(VMAX);
    localparam logic [9:0] c_X_MAX  = 10'(X_MAX);
    localparam logic [8:0] c_Y_MAX  = 9'(Y_MAX);
    localparam logic [9:0] c_Y_MAX10 = 10'(Y_MAX);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    state_t     r_state, w_state_nx;
    logic [9:0] r_x, w_x_nx;
    logic [8:0] r_y, w_y_nx;
    logic [4:0] r_vy, w_vy_nx;
    logic       r_face, w_face_nx;
    logic       r_moving, w_moving_nx;
    logic       r_w_prev;
    logic       w_land;
    logic       w_air_jump;

    logic       w_key_w, w_key_s, w_key_a, w_key_d;
    logic       w_w_edge;
    logic       w_qual, w_init;
    logic [5:0] w_vy_plus;
    logic [4:0] w_vy_fall;
    logic [9:0] w_y_sum;

    assign w_key_w  = wsad_down[3];
    assign w_key_s  = wsad_down[2];
    assign w_key_a  = wsad_down[1];
    assign w_key_d  = wsad_down[0];
    assign w_w_edge = w_key_w & ~r_w_prev;
    assign w_qual   = tick & (game == 2'b01);
    assign w_init   = tick & (game == 2'b00);

    // Falling speed: accelerate by GRAV up to VMAX; S slams straight to VMAX.
    assign w_vy_plus = {1'b0, r_vy} + {1'b0, c_GRAV};
    assign w_vy_fall = w_key_s ? c_VMAX :
                       ((w_vy_plus >= c_VMAX6) ? c_VMAX : w_vy_plus[4:0]);
    assign w_y_sum   = {1'b0, r_y} + {5'b0, w_vy_fall};

`ifdef JACK_DOUBLE_JUMP_EN
    logic r_credit;

    assign w_air_jump = w_w_edge & r_credit & (r_state != ST_GROUND);

    // Air-jump credit: spent by an airborne W edge, refilled on landing/spawn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit <= 1'b1;
        end else if (w_init) begin
            r_credit <= 1'b1;
        end else if (w_qual) begin
            if (w_land) begin
                r_credit <= 1'b1;
            end else if (w_air_jump) begin
                r_credit <= 1'b0;
            end
        end
    end
`else
    assign w_air_jump = 1'b0;
`endif

    // Vertical next-state: state, height and speed for the coming tick.
    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_vy_nx    = r_vy;
        w_land     = 1'b0;
        case (r_state)
            ST_GROUND: begin
                if (w_w_edge) begin
                    w_state_nx = ST_RISE;
                    w_vy_nx    = c_JUMP_V;
                end else if (!on_ground) begin
                    w_state_nx = ST_FALL;
                    w_vy_nx    = '0;
                end
            end
            ST_RISE: begin
                if (w_air_jump) begin
                    w_vy_nx = c_JUMP_V;
                end else if (r_y < {4'b0, r_vy}) begin
                    // Hit the top of the screen: clamp and start falling.
                    w_y_nx     = '0;
                    w_state_nx = ST_FALL;
                    w_vy_nx    = '0;
                end else begin
                    w_y_nx = r_y - {4'b0, r_vy};
                    if (r_vy <= c_GRAV) begin
                        w_state_nx = ST_FALL;
                        w_vy_nx    = '0;
                    end else begin
                        w_vy_nx = r_vy - c_GRAV;
                    end
                end
            end
            ST_FALL: begin
                if (w_air_jump) begin
                    w_state_nx = ST_RISE;
                    w_vy_nx    = c_JUMP_V;
                end else if (on_ground || (w_y_sum >= c_Y_MAX10)) begin
                    w_land     = 1'b1;
                    w_state_nx = ST_GROUND;
                    w_vy_nx    = '0;
                    w_y_nx     = (w_y_sum >= c_Y_MAX10) ? c_Y_MAX : w_y_sum[8:0];
                end else begin
                    w_y_nx  = w_y_sum[8:0];
                    w_vy_nx = w_vy_fall;
                end
            end
            default: begin
                w_state_nx = ST_FALL;
                w_vy_nx    = '0;
            end
        endcase
    end

    // Horizontal next-state: exactly one of A/D steps x, clamped and wall-blocked.
    always_comb begin
        w_x_nx    = r_x;
        w_face_nx = r_face;
        if (w_key_a && !w_key_d) begin
            w_face_nx = 1'b0;
            if (!wall_l) begin
                w_x_nx = (r_x < c_STEP_X) ? '0 : (r_x - c_STEP_X);
            end
        end else if (w_key_d && !w_key_a) begin
            w_face_nx = 1'b1;
            if (!wall_r) begin
                w_x_nx = (r_x >= (c_X_MAX - c_STEP_X)) ? c_X_MAX : (r_x + c_STEP_X);
            end
        end
        w_moving_nx = (w_key_a ^ w_key_d) && (w_x_nx != r_x);
    end

    // State register: async reset, spawn on game=00 tick, advance on qualifying tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_FALL;
            r_x      <= c_X_INIT;
            r_y      <= c_Y_INIT;
            r_vy     <= '0;
            r_face   <= 1'b1;
            r_moving <= 1'b0;
            r_w_prev <= 1'b0;
        end else if (w_init) begin
            r_state  <= ST_FALL;
            r_x      <= c_X_INIT;
            r_y      <= c_Y_INIT;
            r_vy     <= '0;
            r_face   <= 1'b1;
            r_moving <= 1'b0;
        end else if (w_qual) begin
            r_state  <= w_state_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_vy     <= w_vy_nx;
            r_face   <= w_face_nx;
            r_moving <= w_moving_nx;
            r_w_prev <= w_key_w;
        end
    end

    assign x_blue     = r_x;
    assign y_blue     = r_y;
    assign vy         = r_vy;
    assign blue_state = {r_face, (r_state != ST_GROUND), r_moving};

endmodule
`default_nettype wire
